prt_dp_pm_hpd: RTL

//  HPD conditioner in front of the policy-maker PIO inputs.

---
 rtl/prt_dp_pm_hpd.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/prt_dp_pm_hpd.sv
// HPD conditioner: synchronises and glitch-filters the DP hot-plug pin, then classifies plug / unplug / IRQ_HPD.
// Optional build macro PRT_DP_PM_HPD_WIDTH_EN adds WIDTH_OUT (last low-pulse width in us).
module prt_dp_pm_hpd #(
    parameter int P_SYS_FREQ   = 50_000_000,
    parameter int P_FLT_CLKS   = 16,
    parameter int P_IRQ_MIN_US = 250,
    parameter int P_IRQ_MAX_US = 2000,
    parameter int P_PLUG_US    = 2000
) (
    input  logic        CLK_IN,
    input  logic        RST_IN,
    input  logic        EN_IN,
    input  logic        HPD_IN,
    output logic        HPD_OUT,
    output logic        PLUG_OUT,
    output logic        UNPLUG_OUT,
    output logic        IRQ_OUT
`ifdef PRT_DP_PM_HPD_WIDTH_EN
    ,
    output logic [11:0] WIDTH_OUT
`endif
);

    localparam int                 L_DIV       = P_SYS_FREQ / 1_000_000;
    localparam int                 L_PRE_W     = (L_DIV > 1) ? $clog2(L_DIV) : 1;
    localparam logic [L_PRE_W-1:0] L_PRE_LAST  = L_PRE_W'(L_DIV - 1);
    localparam logic [L_PRE_W-1:0] L_PRE_ONE   = L_PRE_W'(1);
    localparam logic [7:0]         L_FLT_LAST  = 8'(P_FLT_CLKS - 1);
    localparam logic [11:0]        L_PLUG      = 12'(P_PLUG_US);
    localparam logic [11:0]        L_IRQ_MIN   = 12'(P_IRQ_MIN_US);
    localparam logic [11:0]        L_UNPLUG_AT = 12'(P_IRQ_MAX_US + 1);
    localparam logic [11:0]        L_US_SAT    = 12'hFFF;

    typedef enum logic [1:0] {
        ST_UNPLUG = 2'b00,
        ST_HIGH   = 2'b01,
        ST_LOW    = 2'b10
    } state_t;

    logic               r_sync1, r_sync2;
    logic               r_flt;
    logic [7:0]         r_flt_cnt;
    logic [L_PRE_W-1:0] r_pre;
    logic [11:0]        r_us;
    state_t             r_state;
    logic               r_hpd, r_plug, r_unplug, r_irq;

    state_t             w_state_nxt;
    logic               w_plug_nxt, w_unplug_nxt, w_irq_nxt;
    logic               w_flip, w_tick;

    // The filtered level flips on the sample that completes the run of differing samples.
    assign w_flip = (r_sync2 != r_flt) && (r_flt_cnt == L_FLT_LAST);
    assign w_tick = (r_pre == L_PRE_LAST);

    // Two-flop synchroniser on the asynchronous pin.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= HPD_IN;
            r_sync2 <= r_sync1;
        end
    end

    // Glitch filter: count consecutive samples that disagree with the accepted level.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_flt     <= 1'b0;
            r_flt_cnt <= 8'd0;
        end else if (r_sync2 == r_flt) begin
            r_flt_cnt <= 8'd0;
        end else if (w_flip) begin
            r_flt     <= ~r_flt;
            r_flt_cnt <= 8'd0;
        end else begin
            r_flt_cnt <= r_flt_cnt + 8'd1;
        end
    end

    // Microsecond prescaler, realigned to every filtered edge.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_pre <= '0;
        end else if (!EN_IN || w_flip || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + L_PRE_ONE;
        end
    end

    // Saturating microsecond counter measuring time since the last filtered edge.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_us <= 12'd0;
        end else if (!EN_IN || w_flip || ((r_state == ST_UNPLUG) && !r_flt)) begin
            r_us <= 12'd0;
        end else if (w_tick && (r_us != L_US_SAT)) begin
            r_us <= r_us + 12'd1;
        end else begin
            r_us <= r_us;
        end
    end

    // Next-state and event decode; a filtered edge takes priority over the unplug timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_plug_nxt   = 1'b0;
        w_unplug_nxt = 1'b0;
        w_irq_nxt    = 1'b0;
        if (!EN_IN) begin
            w_state_nxt  = ST_UNPLUG;
            w_unplug_nxt = (r_state != ST_UNPLUG);
        end else begin
            case (r_state)
                ST_UNPLUG: begin
                    if (r_flt && !w_flip && (r_us == L_PLUG)) begin
                        w_state_nxt = ST_HIGH;
                        w_plug_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_UNPLUG;
                    end
                end
                ST_HIGH: begin
                    if (w_flip) begin
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_state_nxt = ST_HIGH;
                    end
                end
                ST_LOW: begin
                    if (w_flip) begin
                        w_state_nxt = ST_HIGH;
                        w_irq_nxt   = (r_us >= L_IRQ_MIN);
                    end else if (r_us >= L_UNPLUG_AT) begin
                        w_state_nxt  = ST_UNPLUG;
                        w_unplug_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOW;
                    end
                end
                default: begin
                    w_state_nxt = ST_UNPLUG;
                end
            endcase
        end
    end

    // State and registered outputs; HPD_OUT follows the state being entered.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_state  <= ST_UNPLUG;
            r_hpd    <= 1'b0;
            r_plug   <= 1'b0;
            r_unplug <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hpd    <= (w_state_nxt != ST_UNPLUG);
            r_plug   <= w_plug_nxt;
            r_unplug <= w_unplug_nxt;
            r_irq    <= w_irq_nxt;
        end
    end

    assign HPD_OUT    = r_hpd;
    assign PLUG_OUT   = r_plug;
    assign UNPLUG_OUT = r_unplug;
    assign IRQ_OUT    = r_irq;

`ifdef PRT_DP_PM_HPD_WIDTH_EN
    logic [11:0] r_width;
    logic        w_low_exit;

    assign w_low_exit = (r_state == ST_LOW) && (w_state_nxt != ST_LOW);

    // Capture the low-pulse width whenever the LOW state is left.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_width <= 12'd0;
        end else if (w_low_exit) begin
            r_width <= r_us;
        end else begin
            r_width <= r_width;
        end
    end

    assign WIDTH_OUT = r_width;
`endif

endmodule
